// File: rtl/l1_dcache_pkg.sv
// Shared L1 D-cache types and default geometry.
// Used by the tag directory, its sweep controller and the bus interface.
package l1_dcache_pkg;

  localparam int unsigned DefTagW    = 20;
  localparam int unsigned DefNumSets = 64;
  localparam int unsigned DefNumWays = 4;
  localparam int unsigned DefIdxW    = $clog2(DefNumSets);
  localparam int unsigned DefWayW    = $clog2(DefNumWays);

  typedef logic [DefIdxW-1:0] idx_t;
  typedef logic [DefWayW-1:0] way_t;
  typedef logic [DefTagW-1:0] tag_t;

  typedef enum logic [0:0] {
    IDLE,
    SWEEP
  } tag_sweep_state_e;

endpackage

// File: rtl/tag_dir_if.sv
// Lookup, response, update and flush signals of the tag directory.
// The master is the cache controller; the slave is tag_dir.
interface tag_dir_if
  import l1_dcache_pkg::*;
#(
  parameter int unsigned TAG_W    = DefTagW,
  parameter int unsigned NUM_SETS = DefNumSets,
  parameter int unsigned NUM_WAYS = DefNumWays
);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic                      req_valid;
  logic [IDX_W-1:0]          req_index;
  logic [TAG_W-1:0]          req_tag;
  logic                      req_ready;

  logic                      rsp_valid;
  logic                      rsp_hit;
  logic [WAY_W-1:0]          rsp_hit_way;
  logic [NUM_WAYS*TAG_W-1:0] rsp_tag_vec;
  logic [NUM_WAYS-1:0]       rsp_valid_vec;
  logic [NUM_WAYS-1:0]       rsp_dirty_vec;

  logic                      wr_en;
  logic [IDX_W-1:0]          wr_index;
  logic [WAY_W-1:0]          wr_way;
  logic [TAG_W-1:0]          wr_tag;
  logic                      wr_dirty;

  logic                      mark_en;
  logic [IDX_W-1:0]          mark_index;
  logic [WAY_W-1:0]          mark_way;

  logic                      inv_en;
  logic [IDX_W-1:0]          inv_index;
  logic [WAY_W-1:0]          inv_way;

  logic                      flush_req;
  logic                      busy;

  modport master (
    output req_valid, req_index, req_tag,
    output wr_en, wr_index, wr_way, wr_tag, wr_dirty,
    output mark_en, mark_index, mark_way,
    output inv_en, inv_index, inv_way,
    output flush_req,
    input  req_ready, busy,
    input  rsp_valid, rsp_hit, rsp_hit_way, rsp_tag_vec, rsp_valid_vec, rsp_dirty_vec
  );

  modport slave (
    input  req_valid, req_index, req_tag,
    input  wr_en, wr_index, wr_way, wr_tag, wr_dirty,
    input  mark_en, mark_index, mark_way,
    input  inv_en, inv_index, inv_way,
    input  flush_req,
    output req_ready, busy,
    output rsp_valid, rsp_hit, rsp_hit_way, rsp_tag_vec, rsp_valid_vec, rsp_dirty_vec
  );

endinterface

// File: rtl/tag_sweep_ctrl.sv
// Sweep engine: walks every set once after reset or flush, clearing valid/dirty.
// busy is high for exactly NUM_SETS cycles per sweep.
module tag_sweep_ctrl
  import l1_dcache_pkg::*;
#(
  parameter  int unsigned NUM_SETS = DefNumSets,
  localparam int unsigned IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic             busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_index
);

  localparam logic [IDX_W-1:0] LastSet = IDX_W'(NUM_SETS - 1);

  tag_sweep_state_e state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LastSet) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SWEEP;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign clr_en    = (state_q == SWEEP);
  assign clr_index = ptr_q;

endmodule

// File: rtl/tag_dir.sv
// L1 D-cache tag directory: per-line tag/valid/dirty storage with a registered
// lookup that returns hit, hit way and the whole set's victim state.
module tag_dir
  import l1_dcache_pkg::*;
#(
  parameter int unsigned TAG_W    = DefTagW,
  parameter int unsigned NUM_SETS = DefNumSets,
  parameter int unsigned NUM_WAYS = DefNumWays
) (
  input logic       clk,
  input logic       rst_n,
  tag_dir_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];

  logic             busy;
  logic             clr_en;
  logic [IDX_W-1:0] clr_index;

  logic accept;
  logic wr_go;
  logic mark_go;
  logic inv_go;
  logic mark_on_wr;

  logic [NUM_WAYS-1:0]       match;
  logic [WAY_W-1:0]          hit_way;
  logic [NUM_WAYS*TAG_W-1:0] tag_vec;

  logic                      rsp_valid_q;
  logic                      rsp_hit_q;
  logic [WAY_W-1:0]          rsp_hit_way_q;
  logic [NUM_WAYS*TAG_W-1:0] rsp_tag_vec_q;
  logic [NUM_WAYS-1:0]       rsp_valid_vec_q;
  logic [NUM_WAYS-1:0]       rsp_dirty_vec_q;

  tag_sweep_ctrl #(
    .NUM_SETS (NUM_SETS)
  ) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_req (bus.flush_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_index (clr_index)
  );

  assign accept     = bus.req_valid && !busy;
  assign wr_go      = bus.wr_en && !busy;
  assign mark_go    = bus.mark_en && !busy;
  assign inv_go     = bus.inv_en && !busy;
  assign mark_on_wr = mark_go && wr_go && (bus.mark_index == bus.wr_index) &&
                      (bus.mark_way == bus.wr_way);

  // Lowest priority applied first so later statements override on the same line.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (clr_en) begin
      valid_d[clr_index] = '0;
      dirty_d[clr_index] = '0;
    end else begin
      if (mark_go && valid_q[bus.mark_index][bus.mark_way]) begin
        dirty_d[bus.mark_index][bus.mark_way] = 1'b1;
      end
      if (wr_go) begin
        valid_d[bus.wr_index][bus.wr_way] = 1'b1;
        dirty_d[bus.wr_index][bus.wr_way] = bus.wr_dirty | mark_on_wr;
      end
      if (inv_go) begin
        valid_d[bus.inv_index][bus.inv_way] = 1'b0;
        dirty_d[bus.inv_index][bus.inv_way] = 1'b0;
      end
    end
  end

  // Valid/dirty are cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    dirty_q <= dirty_d;
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      tag_q[bus.wr_index][bus.wr_way] <= bus.wr_tag;
    end
  end

  always_comb begin
    match   = '0;
    hit_way = '0;
    tag_vec = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w]                  = valid_q[bus.req_index][w] &&
                                  (tag_q[bus.req_index][w] == bus.req_tag);
      tag_vec[w*TAG_W +: TAG_W] = tag_q[bus.req_index][w];
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) begin
        hit_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_hit_way_q   <= '0;
      rsp_tag_vec_q   <= '0;
      rsp_valid_vec_q <= '0;
      rsp_dirty_vec_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_hit_q       <= |match;
        rsp_hit_way_q   <= hit_way;
        rsp_tag_vec_q   <= tag_vec;
        rsp_valid_vec_q <= valid_q[bus.req_index];
        rsp_dirty_vec_q <= dirty_q[bus.req_index];
      end
    end
  end

  assign bus.req_ready     = !busy;
  assign bus.busy          = busy;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_hit_way   = rsp_hit_way_q;
  assign bus.rsp_tag_vec   = rsp_tag_vec_q;
  assign bus.rsp_valid_vec = rsp_valid_vec_q;
  assign bus.rsp_dirty_vec = rsp_dirty_vec_q;

  // A tag present in two ways of one set means the caller filled a duplicate.
  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) accept |-> $onehot0(match))
    else $error("tag_dir: multiple ways hit in set %0d", bus.req_index);

endmodule

// File: tb/tb_tag_dir.sv
// Self-checking bench for tag_dir: vector table for single operations, hand
// sequences for same-cycle updates, flush and reset-during-sweep.
module tb_tag_dir;

  typedef enum logic [1:0] {OpLook, OpWr, OpMark, OpInv} op_e;

  typedef struct {
    op_e         op;
    logic [5:0]  idx;
    logic [1:0]  way;
    logic [19:0] tag;
    logic        dirty;
    logic        hit;
    logic [1:0]  hway;
    logic [3:0]  vvec;
    logic [3:0]  dvec;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic [3:0]  vvec;
    logic [3:0]  dvec;
    logic [19:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   rsp_id;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[15];

  tag_dir_if #(.TAG_W(20), .NUM_SETS(64), .NUM_WAYS(4)) bus ();

  tag_dir #(.TAG_W(20), .NUM_SETS(64), .NUM_WAYS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard: every response is matched against the oldest pushed expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      rsp_id++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp%0d: unexpected response, got hit=%0b", rsp_id, bus.rsp_hit);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_hit !== e.hit || bus.rsp_hit_way !== e.way ||
            bus.rsp_valid_vec !== e.vvec || bus.rsp_dirty_vec !== e.dvec ||
            (e.hit && bus.rsp_tag_vec[e.way*20 +: 20] !== e.tag)) begin
          errors++;
          $display("FAIL rsp%0d: got hit=%0b way=%0d v=%b d=%b tag=%h, want hit=%0b way=%0d v=%b d=%b tag=%h",
                   rsp_id, bus.rsp_hit, bus.rsp_hit_way, bus.rsp_valid_vec,
                   bus.rsp_dirty_vec, bus.rsp_tag_vec[e.way*20 +: 20],
                   e.hit, e.way, e.vvec, e.dvec, e.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    bus.mark_en   = 1'b0;
    bus.inv_en    = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic set_look(input logic [5:0] idx, input logic [19:0] tag, input logic hit,
                          input logic [1:0] way, input logic [3:0] vvec, input logic [3:0] dvec);
    exp_t x;
    bus.req_valid = 1'b1;
    bus.req_index = idx;
    bus.req_tag   = tag;
    x.hit = hit; x.way = way; x.vvec = vvec; x.dvec = dvec; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic set_wr(input logic [5:0] idx, input logic [1:0] way, input logic [19:0] tag,
                        input logic dirty);
    bus.wr_en = 1'b1; bus.wr_index = idx; bus.wr_way = way;
    bus.wr_tag = tag; bus.wr_dirty = dirty;
  endtask

  task automatic set_mark(input logic [5:0] idx, input logic [1:0] way);
    bus.mark_en = 1'b1; bus.mark_index = idx; bus.mark_way = way;
  endtask

  task automatic set_inv(input logic [5:0] idx, input logic [1:0] way);
    bus.inv_en = 1'b1; bus.inv_index = idx; bus.inv_way = way;
  endtask

  // Counts edges until busy drops while hammering requests that must be ignored.
  task automatic wait_sweep(input string name);
    int cnt = 0;
    bit ok  = 1'b1;
    bus.req_valid = 1'b1; bus.req_index = 6'd0; bus.req_tag = 20'h99999;
    set_wr(6'd0, 2'd0, 20'h99999, 1'b1);
    bus.flush_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.req_ready !== !bus.busy || bus.rsp_valid !== 1'b0) ok = 1'b0;
      if (bus.busy !== 1'b1) break;
    end
    bus.req_valid = 1'b0; bus.wr_en = 1'b0; bus.flush_req = 1'b0;
    chk(cnt == 64, {name, "_busy_cycles"}, 64'(cnt), 64'd64);
    chk(ok, {name, "_ignored_while_busy"}, 64'(ok), 64'd1);
  endtask

  function automatic vec_t mk(op_e op, logic [5:0] idx, logic [1:0] way, logic [19:0] tag,
                              logic dirty, logic hit, logic [1:0] hway, logic [3:0] vvec,
                              logic [3:0] dvec);
    vec_t v;
    v.op = op; v.idx = idx; v.way = way; v.tag = tag; v.dirty = dirty;
    v.hit = hit; v.hway = hway; v.vvec = vvec; v.dvec = dvec;
    return v;
  endfunction

  initial begin
    errors = 0; checks = 0; rsp_id = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_tag = '0;
    bus.wr_en = 1'b0; bus.wr_index = '0; bus.wr_way = '0; bus.wr_tag = '0; bus.wr_dirty = 1'b0;
    bus.mark_en = 1'b0; bus.mark_index = '0; bus.mark_way = '0;
    bus.inv_en = 1'b0; bus.inv_index = '0; bus.inv_way = '0;
    bus.flush_req = 1'b0;

    vecs[0]  = mk(OpLook, 6'd0,  2'd0, 20'h99999, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[1]  = mk(OpLook, 6'd63, 2'd0, 20'h12345, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[2]  = mk(OpWr,   6'd5,  2'd2, 20'h12345, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[3]  = mk(OpLook, 6'd5,  2'd0, 20'h12345, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000);
    vecs[4]  = mk(OpMark, 6'd5,  2'd2, 20'h0,     1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[5]  = mk(OpLook, 6'd5,  2'd0, 20'h12345, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100);
    vecs[6]  = mk(OpMark, 6'd7,  2'd0, 20'h0,     1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[7]  = mk(OpLook, 6'd7,  2'd0, 20'h0,     1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[8]  = mk(OpInv,  6'd5,  2'd2, 20'h0,     1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[9]  = mk(OpLook, 6'd5,  2'd0, 20'h12345, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[10] = mk(OpWr,   6'd5,  2'd0, 20'h12345, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[11] = mk(OpWr,   6'd5,  2'd3, 20'h55555, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    vecs[12] = mk(OpLook, 6'd5,  2'd0, 20'h55555, 1'b0, 1'b1, 2'd3, 4'b1001, 4'b0001);
    vecs[13] = mk(OpLook, 6'd5,  2'd0, 20'h12345, 1'b0, 1'b1, 2'd0, 4'b1001, 4'b0001);
    vecs[14] = mk(OpLook, 6'd9,  2'd0, 20'hABCDE, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);

    // Reset state
    repeat (3) step();
    chk(bus.busy === 1'b1, "reset_busy", 64'(bus.busy), 64'd1);
    chk(bus.req_ready === 1'b0, "reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk(bus.rsp_valid === 1'b0, "reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk(bus.rsp_hit === 1'b0, "reset_rsp_hit", 64'(bus.rsp_hit), 64'd0);
    rst_n = 1'b1;
    wait_sweep("init");

    for (int i = 0; i < 15; i++) begin
      unique case (vecs[i].op)
        OpLook: set_look(vecs[i].idx, vecs[i].tag, vecs[i].hit, vecs[i].hway,
                         vecs[i].vvec, vecs[i].dvec);
        OpWr:   set_wr(vecs[i].idx, vecs[i].way, vecs[i].tag, vecs[i].dirty);
        OpMark: set_mark(vecs[i].idx, vecs[i].way);
        OpInv:  set_inv(vecs[i].idx, vecs[i].way);
      endcase
      step();
    end

    // Same-cycle fill and lookup sees old contents; the next lookup hits
    set_wr(6'd9, 2'd1, 20'hABCDE, 1'b0);
    set_look(6'd9, 20'hABCDE, 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();
    set_look(6'd9, 20'hABCDE, 1'b1, 2'd1, 4'b0010, 4'b0000);
    step();

    // Same-line priorities
    set_wr(6'd10, 2'd0, 20'hAAAAA, 1'b0);
    set_mark(6'd10, 2'd0);
    step();
    set_look(6'd10, 20'hAAAAA, 1'b1, 2'd0, 4'b0001, 4'b0001);
    step();
    set_wr(6'd11, 2'd1, 20'hBBBBB, 1'b1);
    step();
    set_inv(6'd11, 2'd1);
    set_wr(6'd11, 2'd1, 20'hBBBBB, 1'b0);
    set_mark(6'd11, 2'd1);
    step();
    set_look(6'd11, 20'hBBBBB, 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();

    // Different lines in one cycle all take effect
    set_wr(6'd12, 2'd0, 20'hCCCCC, 1'b0);
    set_inv(6'd5, 2'd0);
    set_mark(6'd5, 2'd3);
    step();
    set_look(6'd12, 20'hCCCCC, 1'b1, 2'd0, 4'b0001, 4'b0000);
    step();
    set_look(6'd5, 20'h55555, 1'b1, 2'd3, 4'b1000, 4'b1000);
    step();

    // Flush clears fully populated sets
    for (int w = 0; w < 4; w++) begin
      set_wr(6'd0, 2'(w), 20'h10000 + 20'(w), w[0]);
      step();
      set_wr(6'd63, 2'(w), 20'h63000 + 20'(w), w[0]);
      step();
    end
    set_look(6'd0, 20'h10002, 1'b1, 2'd2, 4'b1111, 4'b1010);
    step();
    set_look(6'd63, 20'h63003, 1'b1, 2'd3, 4'b1111, 4'b1010);
    step();
    bus.flush_req = 1'b1;
    step();
    chk(bus.busy === 1'b1, "flush_busy_start", 64'(bus.busy), 64'd1);
    wait_sweep("flush");
    set_look(6'd0, 20'h10002, 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();
    set_look(6'd63, 20'h63003, 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();

    // Response registers hold when no request is accepted
    set_wr(6'd20, 2'd1, 20'h24680, 1'b1);
    step();
    set_look(6'd20, 20'h24680, 1'b1, 2'd1, 4'b0010, 4'b0010);
    step();
    step();
    chk(bus.rsp_valid === 1'b0, "hold_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk(bus.rsp_hit === 1'b1 && bus.rsp_hit_way === 2'd1, "hold_rsp_hit",
        {62'd0, bus.rsp_hit, bus.rsp_hit_way[0]}, 64'd3);

    // Reset 30 cycles into a sweep restarts it from set 0
    bus.flush_req = 1'b1;
    step();
    repeat (30) step();
    rst_n = 1'b0;
    step();
    chk(bus.busy === 1'b1, "midreset_busy", 64'(bus.busy), 64'd1);
    chk(bus.rsp_hit === 1'b0 && bus.rsp_hit_way === 2'd0, "midreset_rsp_hit",
        {61'd0, bus.rsp_hit, bus.rsp_hit_way}, 64'd0);
    chk(bus.rsp_valid_vec === 4'd0 && bus.rsp_dirty_vec === 4'd0, "midreset_rsp_vecs",
        {56'd0, bus.rsp_valid_vec, bus.rsp_dirty_vec}, 64'd0);
    chk(bus.rsp_tag_vec === 80'd0, "midreset_rsp_tag_vec", bus.rsp_tag_vec[63:0], 64'd0);
    rst_n = 1'b1;
    wait_sweep("midreset");
    set_look(6'd20, 20'h24680, 1'b0, 2'd0, 4'b0000, 4'b0000);
    step();
    step();
    step();

    chk(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_dir.md
Name: tag_dir

Overview:
Next-generation L1 D-cache tag directory. It stores tag, valid and dirty state per set/way and performs a registered lookup with per-way hit compare. Victim state (tags and dirty bits) is returned alongside the lookup for writeback decisions. A built-in sweep engine clears all valid/dirty state after reset and on a flush request, so lookups never see power-up garbage.

Parameters:
TAG_W, 20, tag width in bits
NUM_SETS, 64, number of sets; power of 2, >=2
NUM_WAYS, 4, associativity; power of 2, >=2
IDX_W, $clog2(NUM_SETS), index width (derived, not overridden)
WAY_W, $clog2(NUM_WAYS), way-select width (derived, not overridden)

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
req_valid  in  1  lookup request
req_index  in  IDX_W  lookup set
req_tag  in  TAG_W  lookup tag
req_ready  out  1  =!busy; request accepted when req_valid&&req_ready
rsp_valid  out  1  lookup result valid, 1 cycle after acceptance
rsp_hit  out  1  some way valid with matching tag
rsp_hit_way  out  WAY_W  lowest matching way; 0 when no hit
rsp_tag_vec  out  NUM_WAYS*TAG_W  stored tags of the set, way 0 in LSBs
rsp_valid_vec  out  NUM_WAYS  valid bits of the set
rsp_dirty_vec  out  NUM_WAYS  dirty bits of the set
wr_en, wr_index, wr_way, wr_tag, wr_dirty  in  1/IDX_W/WAY_W/TAG_W/1  fill: tag<=wr_tag, valid<=1, dirty<=wr_dirty
mark_en, mark_index, mark_way  in  1/IDX_W/WAY_W  set dirty (store hit); no effect on invalid line
inv_en, inv_index, inv_way  in  1/IDX_W/WAY_W  clear valid and dirty of one line
flush_req  in  1  single-cycle pulse: start full sweep
busy  out  1  sweep in progress

Behaviour:
- Reset (rst_n=0 at a posedge): state<=SWEEP, sweep_ptr<=0, busy<=1, rsp_valid<=0, rsp_hit<=0, rsp_hit_way<=0, rsp_*_vec<=0. Tag storage is not reset.
- FSM states IDLE and SWEEP.
  - SWEEP: each cycle clears valid/dirty of all ways in set sweep_ptr, then sweep_ptr++.
  - After set NUM_SETS-1 is cleared: state->IDLE, busy=0 on the next cycle. busy is high for exactly NUM_SETS cycles.
  - IDLE + flush_req -> SWEEP next cycle, sweep_ptr=0.
- While busy: req_valid, wr_en, mark_en, inv_en and flush_req are ignored. rsp_valid stays 0.
- Reset asserted mid-sweep restarts the sweep from set 0.
- Lookup:
  - Request accepted in cycle N.
  - In cycle N+1: rsp_valid=1 and all rsp_* reflect array contents as of the start of cycle N, i.e. pre-update; no bypass of same-cycle writes.
  - rsp_* hold their last values when rsp_valid=0.
- Hit logic:
  - Per-way match = valid && tag==req_tag.
  - rsp_hit = OR of matches; rsp_hit_way = lowest matching index.
  - Multi-hit is a caller contract violation. Lowest-way still wins; an assertion flags it in simulation.
- Updates in the same cycle:
  - Operations targeting different lines all take effect.
  - Same line: priority inv > wr > mark.
  - wr with wr_dirty=0 plus mark on the same line: dirty=1 (mark ORs in after wr).
- All updates are visible to lookups accepted in the following cycle.

Decomposition:
- Shared package l1_dcache_pkg:
  - TAG_W/NUM_SETS/NUM_WAYS defaults
  - idx_t, way_t, tag_t typedefs
  - enum tag_sweep_state_e {IDLE, SWEEP}
- One sub-module, tag_sweep_ctrl: the FSM, sweep_ptr counter and busy output. It drives a clear-enable and clear-index into tag_dir.
- Storage, hit compare and response registers stay in tag_dir.

Test Plan:
- Reset, then release: busy=1 for exactly 64 cycles, req_ready=0 throughout; first lookup of any set -> rsp_valid=1, rsp_hit=0, rsp_valid_vec=4'b0000.
- Fill set 5 way 2 with tag 0x12345, wr_dirty=0; lookup set 5 tag 0x12345 next cycle -> rsp_hit=1, rsp_hit_way=2, rsp_valid_vec=4'b0100, rsp_dirty_vec=0.
- mark set 5 way 2, then lookup -> rsp_dirty_vec=4'b0100. mark set 7 way 0 (invalid line) -> set 7 dirty stays 0.
- inv set 5 way 2, then lookup tag 0x12345 -> rsp_hit=0, valid and dirty bits for way 2 both 0.
- Same cycle: wr set 9 way 1 tag 0xABCDE plus lookup set 9 tag 0xABCDE -> miss (old contents); repeat lookup next cycle -> hit, way 1.
- Fill all 4 ways of sets 0 and 63, pulse flush_req: busy=1 for 64 cycles, requests ignored; lookups of sets 0 and 63 afterward -> rsp_valid_vec=0. Reset asserted at sweep cycle 30 -> busy for a full 64 cycles after release.
